// File: rtl/alu_interface.sv
// Byte-serial front end for a combinational ALU: collects two operands and an
// opcode from the receiver, then hands the ALU result to the transmitter.
//
// state   | meaning
// GET_A   | waiting for first operand byte
// GET_B   | waiting for second operand byte
// GET_OP  | waiting for opcode byte
// EXEC    | one cycle for the ALU output to settle, result captured at its end
// WAIT_TX | result handed to transmitter, waiting for tx_done
module alu_interface #(
    parameter int N_BITS  = 8,
    parameter int OP_BITS = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_done,
    input  logic [N_BITS-1:0]  alu_result,
    input  logic               tx_done,
    output logic [N_BITS-1:0]  d0,
    output logic [N_BITS-1:0]  d1,
    output logic [OP_BITS-1:0] opcode,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    output logic               busy,
    output logic               rx_drop
);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic ld_a;
    logic ld_b;
    logic ld_op;
    logic ld_tx;
    logic drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= GET_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            GET_A:   if (rx_done) state_nxt = GET_B;
            GET_B:   if (rx_done) state_nxt = GET_OP;
            GET_OP:  if (rx_done) state_nxt = EXEC;
            EXEC:    state_nxt = WAIT_TX;
            WAIT_TX: if (tx_done) state_nxt = GET_A;
            default: state_nxt = GET_A;
        endcase
    end

    always_comb begin
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        ld_op = 1'b0;
        ld_tx = 1'b0;
        drop  = 1'b0;
        busy  = 1'b0;
        case (state)
            GET_A:   ld_a  = rx_done;
            GET_B:   ld_b  = rx_done;
            GET_OP:  ld_op = rx_done;
            EXEC: begin
                ld_tx = 1'b1;
                drop  = rx_done;
                busy  = 1'b1;
            end
            WAIT_TX: begin
                drop  = rx_done;
                busy  = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand/result registers hold across transactions; only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0       <= '0;
            d1       <= '0;
            opcode   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            rx_drop  <= 1'b0;
        end else begin
            if (ld_a)  d0     <= rx_data[N_BITS-1:0];
            if (ld_b)  d1     <= rx_data[N_BITS-1:0];
            if (ld_op) opcode <= rx_data[OP_BITS-1:0];
            if (ld_tx) tx_data <= 8'(alu_result);
            tx_start <= ld_tx;
            if (drop)  rx_drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_interface.sv
// Directed bench for alu_interface with a small reference ALU hooked downstream.
module tb_alu_interface;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_result;
    logic       tx_done;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [5:0] opcode;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       rx_drop;

    int checks = 0;
    int errors = 0;

    alu_interface #(.N_BITS(8), .OP_BITS(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .alu_result (alu_result),
        .tx_done    (tx_done),
        .d0         (d0),
        .d1         (d1),
        .opcode     (opcode),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .rx_drop    (rx_drop)
    );

    always #5 clk = ~clk;

    // Reference ALU: add, sub, and, or; anything else yields zero.
    always_comb begin
        alu_result = 8'h00;
        case (opcode)
            6'h20: alu_result = d0 + d1;
            6'h22: alu_result = d0 - d1;
            6'h24: alu_result = d0 & d1;
            6'h25: alu_result = d0 | d1;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Sends a full transaction and leaves the DUT in its second WAIT_TX cycle.
    task automatic txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] op, input logic [5:0] op_exp, input logic [7:0] res);
        send_byte(a);
        chk({tag, " d0"}, d0, a);
        chk({tag, " busy_getb"}, {7'd0, busy}, 8'd0);
        send_byte(b);
        chk({tag, " d1"}, d1, b);
        send_byte(op);
        chk({tag, " opcode"}, {2'b00, opcode}, {2'b00, op_exp});
        chk({tag, " busy_exec"}, {7'd0, busy}, 8'd1);
        chk({tag, " tx_start_exec"}, {7'd0, tx_start}, 8'd0);
        @(negedge clk);
        chk({tag, " tx_start_pulse"}, {7'd0, tx_start}, 8'd1);
        chk({tag, " tx_data"}, tx_data, res);
        @(negedge clk);
        chk({tag, " tx_start_low"}, {7'd0, tx_start}, 8'd0);
        chk({tag, " busy_wait"}, {7'd0, busy}, 8'd1);
    endtask

    task automatic finish_tx(input string tag);
        pulse_tx_done();
        chk({tag, " busy_done"}, {7'd0, busy}, 8'd0);
        chk({tag, " tx_start_done"}, {7'd0, tx_start}, 8'd0);
    endtask

    initial begin
        reset   = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst d0", d0, 8'h00);
        chk("rst d1", d1, 8'h00);
        chk("rst opcode", {2'b00, opcode}, 8'h00);
        chk("rst tx_data", tx_data, 8'h00);
        chk("rst tx_start", {7'd0, tx_start}, 8'd0);
        chk("rst busy", {7'd0, busy}, 8'd0);
        chk("rst rx_drop", {7'd0, rx_drop}, 8'd0);
        reset = 1'b0;

        // Add, with transmitter holding off for a few cycles
        txn("add", 8'h05, 8'h03, 8'h20, 6'h20, 8'h08);
        repeat (3) @(negedge clk);
        chk("add busy_hold", {7'd0, busy}, 8'd1);
        chk("add tx_start_hold", {7'd0, tx_start}, 8'd0);
        finish_tx("add");

        // Subtract wraps; undefined opcode truncated to 6 bits
        txn("sub", 8'h03, 8'h05, 8'h22, 6'h22, 8'hFE);
        finish_tx("sub");
        txn("undef", 8'h03, 8'h05, 8'hFF, 6'h3F, 8'h00);

        // Byte arriving while busy is dropped
        send_byte(8'hAA);
        chk("drop d0", d0, 8'h03);
        chk("drop d1", d1, 8'h05);
        chk("drop opcode", {2'b00, opcode}, 8'h3F);
        chk("drop flag", {7'd0, rx_drop}, 8'd1);
        chk("drop busy", {7'd0, busy}, 8'd1);
        finish_tx("drop");
        chk("drop sticky1", {7'd0, rx_drop}, 8'd1);
        txn("after_drop", 8'h05, 8'h03, 8'h20, 6'h20, 8'h08);
        finish_tx("after_drop");
        chk("drop sticky2", {7'd0, rx_drop}, 8'd1);

        // Stray tx_done in each collection state changes nothing
        pulse_tx_done();
        chk("stray geta busy", {7'd0, busy}, 8'd0);
        chk("stray geta tx_start", {7'd0, tx_start}, 8'd0);
        send_byte(8'h01);
        pulse_tx_done();
        chk("stray getb tx_start", {7'd0, tx_start}, 8'd0);
        send_byte(8'h02);
        chk("stray d1", d1, 8'h02);
        pulse_tx_done();
        chk("stray getop busy", {7'd0, busy}, 8'd0);
        chk("stray getop tx_start", {7'd0, tx_start}, 8'd0);
        send_byte(8'h20);
        chk("stray busy_exec", {7'd0, busy}, 8'd1);
        @(negedge clk);
        chk("stray tx_start", {7'd0, tx_start}, 8'd1);
        chk("stray tx_data", tx_data, 8'h03);
        finish_tx("stray");

        // Asynchronous reset mid-sequence
        send_byte(8'h07);
        chk("midrst d0", d0, 8'h07);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst d0_clr", d0, 8'h00);
        chk("midrst tx_data_clr", tx_data, 8'h00);
        chk("midrst opcode_clr", {2'b00, opcode}, 8'h00);
        chk("midrst rx_drop_clr", {7'd0, rx_drop}, 8'd0);
        chk("midrst busy_clr", {7'd0, busy}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        txn("or", 8'h0F, 8'hF0, 8'h25, 6'h25, 8'hFF);
        chk("or rx_drop", {7'd0, rx_drop}, 8'd0);

        // Simultaneous rx_done and tx_done in WAIT_TX
        @(negedge clk);
        rx_data = 8'h55;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        rx_data = 8'h00;
        chk("both busy", {7'd0, busy}, 8'd0);
        chk("both rx_drop", {7'd0, rx_drop}, 8'd1);
        chk("both d0", d0, 8'h0F);
        txn("post_both", 8'h06, 8'h02, 8'h24, 6'h24, 8'h02);
        finish_tx("post_both");
        chk("post_both rx_drop", {7'd0, rx_drop}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
